// File: rtl/edge_det_pkg.sv
// Shared types and helpers for the multi-channel edge detector.
// Mode encoding and the per-channel hit decode live here.
package edge_det_pkg;

    typedef enum logic [1:0] {
        ED_OFF  = 2'b00,
        ED_RISE = 2'b01,
        ED_FALL = 2'b10,
        ED_BOTH = 2'b11
    } ed_mode_e;

    function automatic logic edge_hit(
        input ed_mode_e mode,
        input logic     s,
        input logic     prev
    );
        logic rise;
        logic fall;
        logic hit;
        rise = s & ~prev;
        fall = ~s & prev;
        hit  = 1'b0;
        case (mode)
            ED_RISE: hit = rise;
            ED_FALL: hit = fall;
            ED_BOTH: hit = rise | fall;
            default: hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/multi_edge_detector_ch.sv
// One edge-detector channel: synchroniser, previous level, pulse,
// sticky flag and saturating event counter.
module multi_edge_detector_ch
    import edge_det_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             signal_i,
    input  logic [1:0]       mode_i,
    input  logic             warm_i,
    input  logic             clr_i,
    input  logic             cnt_clr_i,
    output logic             ed_o,
    output logic             sticky_o,
    output logic             sticky_d_o,
    output logic [CNT_W-1:0] cnt_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             s;
    logic             prev_q;
    logic             ed_q;
    logic             ed_d;
    logic             sticky_q;
    logic             sticky_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign s = signal_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= signal_i;
                    for (int k = 1; k < SYNC_STAGES; k++) begin
                        sync_q[k] <= sync_q[k-1];
                    end
                end
            end
            assign s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // prev follows s in every mode so a mode switch never sees a stale level
    always_comb begin
        ed_d     = ~warm_i & edge_hit(ed_mode_e'(mode_i), s, prev_q);
        sticky_d = ed_d | (sticky_q & ~clr_i);
        cnt_d    = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = ed_d ? CNT_ONE : '0;
        end else if (ed_d && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q   <= 1'b0;
            ed_q     <= 1'b0;
            sticky_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            prev_q   <= s;
            ed_q     <= ed_d;
            sticky_q <= sticky_d;
            cnt_q    <= cnt_d;
        end
    end

    assign ed_o       = ed_q;
    assign sticky_o   = sticky_q;
    assign sticky_d_o = sticky_d;
    assign cnt_o      = cnt_q;

endmodule

// File: rtl/multi_edge_detector.sv
// Multi-channel edge detector top: global warm-up after reset,
// per-channel instances and the masked, registered interrupt.
module multi_edge_detector
    import edge_det_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       signal,
    input  logic [2*NUM_CH-1:0]     mode,
    input  logic [NUM_CH-1:0]       irq_en,
    input  logic [NUM_CH-1:0]       clr,
    input  logic                    cnt_clr,
    output logic [NUM_CH-1:0]       ed,
    output logic [NUM_CH-1:0]       evt_sticky,
    output logic [NUM_CH*CNT_W-1:0] evt_cnt,
    output logic                    irq
);

    localparam int WW = $clog2(SYNC_STAGES + 2);
    localparam logic [WW-1:0] WARM_LAST = WW'(SYNC_STAGES + 1);

    logic [WW-1:0]     warm_q;
    logic [WW-1:0]     warm_d;
    logic              warm;
    logic [NUM_CH-1:0] sticky_d;
    logic              irq_q;
    logic              irq_d;

    // hits are masked until the sync chain and prev hold the real level
    assign warm = (warm_q != WARM_LAST);

    always_comb begin
        warm_d = warm_q;
        if (warm) begin
            warm_d = warm_q + WW'(1);
        end
        irq_d = |(sticky_d & irq_en);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warm_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            warm_q <= warm_d;
            irq_q  <= irq_d;
        end
    end

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            multi_edge_detector_ch #(
                .SYNC_STAGES (SYNC_STAGES),
                .CNT_W       (CNT_W)
            ) u_ch (
                .clk        (clk),
                .rst        (rst),
                .signal_i   (signal[i]),
                .mode_i     (mode[2*i +: 2]),
                .warm_i     (warm),
                .clr_i      (clr[i]),
                .cnt_clr_i  (cnt_clr),
                .ed_o       (ed[i]),
                .sticky_o   (evt_sticky[i]),
                .sticky_d_o (sticky_d[i]),
                .cnt_o      (evt_cnt[CNT_W*i +: CNT_W])
            );
        end
    endgenerate

    assign irq = irq_q;

endmodule

// File: tb/tb_multi_edge_detector.sv
// Directed bench for multi_edge_detector (NUM_CH=4, SYNC_STAGES=2, CNT_W=2).
// A vector table covers the basic path; short sequences cover corner cases.
module tb_multi_edge_detector;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] signal;
    logic [7:0] mode;
    logic [3:0] irq_en;
    logic [3:0] clr;
    logic       cnt_clr;
    logic [3:0] ed;
    logic [3:0] evt_sticky;
    logic [7:0] evt_cnt;
    logic       irq;

    int n_total = 0;
    int n_pass  = 0;

    multi_edge_detector #(
        .NUM_CH      (4),
        .SYNC_STAGES (2),
        .CNT_W       (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .signal     (signal),
        .mode       (mode),
        .irq_en     (irq_en),
        .clr        (clr),
        .cnt_clr    (cnt_clr),
        .ed         (ed),
        .evt_sticky (evt_sticky),
        .evt_cnt    (evt_cnt),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] sig;
        logic [3:0] clr;
        logic       cclr;
        logic [3:0] ed;
        logic [3:0] stk;
        logic [7:0] cnt;
        logic       irq;
    } vec_t;

    vec_t vecs[12];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic reset_dut(input logic [3:0] sig);
        signal  = sig;
        clr     = '0;
        cnt_clr = 1'b0;
        rst     = 1'b1;
        tick();
        check("rst_ed", 32'(ed), 32'h0);
        check("rst_sticky", 32'(evt_sticky), 32'h0);
        check("rst_cnt", 32'(evt_cnt), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        rst = 1'b0;
        repeat (3) tick();
    endtask

    logic [3:0] ed_or;
    logic [9:0] ed_hist;
    int         pulses;

    initial begin
        rst     = 1'b1;
        signal  = '0;
        mode    = '0;
        irq_en  = '0;
        clr     = '0;
        cnt_clr = 1'b0;

        vecs[0]  = '{4'h1, 4'h0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0};
        vecs[1]  = '{4'h1, 4'h0, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0};
        vecs[2]  = '{4'h1, 4'h0, 1'b0, 4'h1, 4'h1, 8'h01, 1'b1};
        vecs[3]  = '{4'h1, 4'h0, 1'b0, 4'h0, 4'h1, 8'h01, 1'b1};
        vecs[4]  = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h1, 8'h01, 1'b1};
        vecs[5]  = '{4'h0, 4'h0, 1'b0, 4'h0, 4'h1, 8'h01, 1'b1};
        vecs[6]  = '{4'h0, 4'h0, 1'b0, 4'h1, 4'h1, 8'h02, 1'b1};
        vecs[7]  = '{4'h0, 4'h1, 1'b0, 4'h0, 4'h0, 8'h02, 1'b0};
        vecs[8]  = '{4'h4, 4'h0, 1'b0, 4'h0, 4'h0, 8'h02, 1'b0};
        vecs[9]  = '{4'h4, 4'h0, 1'b0, 4'h0, 4'h0, 8'h02, 1'b0};
        vecs[10] = '{4'h4, 4'h0, 1'b0, 4'h4, 4'h4, 8'h12, 1'b0};
        vecs[11] = '{4'h4, 4'h0, 1'b1, 4'h0, 4'h4, 8'h00, 1'b0};

        // Table: all channels in both-edge mode, irq on ch0 only
        mode   = 8'hFF;
        irq_en = 4'h1;
        reset_dut(4'h0);
        for (int i = 0; i < 12; i++) begin
            signal  = vecs[i].sig;
            clr     = vecs[i].clr;
            cnt_clr = vecs[i].cclr;
            tick();
            check($sformatf("vec%0d_ed", i), 32'(ed), 32'(vecs[i].ed));
            check($sformatf("vec%0d_stk", i), 32'(evt_sticky), 32'(vecs[i].stk));
            check($sformatf("vec%0d_cnt", i), 32'(evt_cnt), 32'(vecs[i].cnt));
            check($sformatf("vec%0d_irq", i), 32'(irq), 32'(vecs[i].irq));
        end
        clr     = '0;
        cnt_clr = 1'b0;

        // High level held through reset: warm-up hides it
        mode   = 8'h55;
        irq_en = 4'h0;
        reset_dut(4'hF);
        ed_or = '0;
        repeat (6) begin
            tick();
            ed_or |= ed;
        end
        check("warm_no_ed", 32'(ed_or), 32'h0);
        check("warm_cnt", 32'(evt_cnt), 32'h0);
        signal = 4'hB;
        ed_or  = '0;
        pulses = 0;
        repeat (3) begin
            tick();
            ed_or |= ed;
        end
        signal = 4'hF;
        repeat (4) begin
            tick();
            ed_or |= ed;
            if (ed[2]) pulses++;
        end
        check("rise_ch2_only", 32'(ed_or), 32'h4);
        check("rise_ch2_pulses", 32'(pulses), 32'd1);
        check("rise_ch2_cnt", 32'(evt_cnt), 32'h10);

        // Toggle every cycle: ed held six cycles, counter saturates
        mode = 8'h0C;
        reset_dut(4'h0);
        ed_hist = '0;
        for (int i = 0; i < 10; i++) begin
            if (i < 6) signal[1] = ~signal[1];
            tick();
            ed_hist[i] = ed[1];
        end
        check("toggle_ed_run", 32'(ed_hist), 32'h0FC);
        check("toggle_cnt_sat", 32'(evt_cnt), 32'h0C);

        // clr in the same cycle as a hit: set wins
        mode = 8'h40;
        reset_dut(4'h0);
        signal = 4'h8;
        tick();
        tick();
        clr = 4'h8;
        tick();
        check("clr_hit_ed", 32'(ed), 32'h8);
        check("clr_hit_stk", 32'(evt_sticky), 32'h8);
        tick();
        check("clr_alone_stk", 32'(evt_sticky), 32'h0);
        clr = '0;

        // Masked interrupt
        mode   = 8'hFF;
        irq_en = 4'h4;
        reset_dut(4'h0);
        signal = 4'h1;
        repeat (3) tick();
        check("irq_ch0_ed", 32'(ed), 32'h1);
        check("irq_ch0_masked", 32'(irq), 32'h0);
        signal = 4'h5;
        repeat (3) tick();
        check("irq_ch2_ed", 32'(ed), 32'h4);
        check("irq_ch2_high", 32'(irq), 32'h1);
        clr = 4'h4;
        tick();
        check("irq_clr_low", 32'(irq), 32'h0);
        check("irq_clr_stk", 32'(evt_sticky), 32'h1);
        clr = '0;

        // Reset while an edge is in the sync chain
        mode   = 8'h03;
        irq_en = 4'h0;
        reset_dut(4'h0);
        signal = 4'h1;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ed", 32'(ed), 32'h0);
        tick();
        rst   = 1'b0;
        ed_or = '0;
        repeat (6) begin
            tick();
            ed_or |= ed;
        end
        check("midrst_no_ed", 32'(ed_or), 32'h0);
        check("midrst_cnt", 32'(evt_cnt), 32'h0);

        // Signal falls while off; enabling fall must not fire
        mode   = 8'h00;
        signal = 4'h0;
        repeat (4) tick();
        mode  = 8'h02;
        ed_or = '0;
        repeat (4) begin
            tick();
            ed_or |= ed;
        end
        check("off_to_fall_ed", 32'(ed_or), 32'h0);
        check("off_to_fall_stk", 32'(evt_sticky), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
